jtframe_bank_responder: RTL and testbench
=========================================

Name: jtframe_bank_responder

Overview:
- Memory-side responder for one JTFRAME SDRAM bank request channel: addr/rd/wr/din/din_m in; ack/dst/dok/rdy/dout out.
- Backed by an internal synchronous RAM of 2**AW 16-bit words.
- Lets cores and simulation benches run a game's bank interface without the SDRAM controller.
- Also accepts ROM-load writes (prog_*), which take priority over game requests.

Parameters:
- AW, 12, word address width; memory depth 2**AW words.
- LAT, 3, cycles from the ack pulse to the first data word (dst); legal range 1..15.
- BURST, 2, 16-bit words returned per read; legal 1..4; addresses increment and wrap modulo 2**AW.
- REFRESH, 64, refresh interval in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  AW  word address; held stable by the requester from rd/wr rise until rdy
- rd  in  1  read request level; held until rdy
- wr  in  1  write request level; held until rdy; rd and wr both high is treated as write
- din  in  16  write data
- din_m  in  2  byte mask; bit1 = upper, bit0 = lower; 1 = byte NOT written
- dout  out  16  read data
- ack  out  1  one-cycle pulse: request accepted, addr may change after rdy
- dst  out  1  one-cycle pulse coincident with the first read word
- dok  out  1  high for each cycle dout carries a valid read word
- rdy  out  1  one-cycle pulse: transaction finished (last read word, or write committed)
- prog_addr  in  AW  ROM-load word address
- prog_data  in  16  ROM-load data
- prog_mask  in  2  ROM-load byte mask; same polarity as din_m
- prog_we  in  1  ROM-load write strobe, one word per high cycle
- prog_rdy  out  1  one-cycle pulse the cycle after each committed prog write
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - dout=0; ack, dst, dok, rdy, prog_rdy, busy=0.
  - Latency and burst counters=0.
  - Memory contents are not cleared.
- States: IDLE, ACK, WAIT, DATA, WRITE, plus REFR with the feature.
- IDLE:
  - prog_we high: write memory at prog_addr (masked); prog_rdy=1 on the next cycle; stay in IDLE.
  - Otherwise wr high: go to ACK with op=write.
  - Otherwise rd high: go to ACK with op=read.
  - A request present in the same cycle as prog_we is not lost; it is accepted on the first cycle prog_we is low.
- ACK (one cycle): ack=1; latch addr into an internal pointer.
  - Write: go to WRITE.
  - Read: load the latency counter with LAT-1 and go to WAIT.
- WRITE (one cycle): commit din to mem[ptr], bytes masked per din_m; rdy=1; return to IDLE.
- WAIT: decrement the counter; at 0 go to DATA.
  - Exact read timing: ack at cycle T; dst and first dok at T+LAT.
- DATA (BURST cycles):
  - Each cycle: dout=mem[ptr], dok=1; ptr increments with wrap (2**AW-1 -> 0).
  - dst=1 on the first word only.
  - rdy=1 together with the last word, then return to IDLE.
  - BURST=1: dst, dok and rdy all assert in the same cycle.
- prog_we during ACK, WAIT, DATA or WRITE:
  - The write is performed immediately with its own prog_rdy pulse.
  - A read in progress returns data from the RAM's second port: the prog write wins any same-word collision on the following read cycle.
- rd/wr dropped before rdy: the transaction still completes; the requester ignores the outputs. A new request needs rd/wr sampled in IDLE.
- dout holds its last value outside DATA; dok gates validity.
- Back-to-back: rd held high after rdy is accepted again as a new request (ack on the cycle after IDLE is re-entered). Minimum read cycle is LAT+BURST+1 clocks.

Optional Feature:
- Macro: JTFRAME_BANK_REFRESH_EN.
- Enabled:
  - A free-running counter raises a refresh request every REFRESH cycles.
  - The request is serviced only from IDLE: state REFR for 4 cycles; busy=1; new game requests and prog writes are held off (prog_we is buffered, depth 1).
  - A pending refresh has priority over a pending game request; the game request is accepted right after REFR.
  - This emulates SDRAM stall jitter for the requester.
- Disabled: no refresh logic; the REFR state does not exist.

Test Plan:
- Read latency, AW=12, LAT=3, BURST=2: preload mem[0x010]=0x1234, mem[0x011]=0xABCD; pulse rd with addr=0x010 -> ack at T, dst+dok with dout=0x1234 at T+3, dok+rdy with dout=0xABCD at T+4.
- Masked write: mem[0x020]=0xFFFF; wr with din=0x5A5A, din_m=2'b01 -> rdy 2 cycles after the request; subsequent read returns 0x5AFF.
- Address wrap: BURST=2, addr=0xFFF, mem[0xFFF]=0x0001, mem[0x000]=0x0002 -> words 0x0001 then 0x0002.
- ROM-load priority: prog_we with prog_addr=0x030, data=0xBEEF in the same cycle as rd -> prog_rdy next cycle, ack one cycle later than the no-conflict case; read of 0x030 returns 0xBEEF.
- Reset mid-read: assert rst during WAIT -> all outputs 0 immediately; after release, no dst or rdy is emitted until a new rd.
- With JTFRAME_BANK_REFRESH_EN, REFRESH=64: rd asserted on the cycle the refresh fires -> ack delayed by exactly 4 cycles; without the macro, ack follows after 1 cycle.

Source files
------------

// File: rtl/jtframe_bank_responder.sv
// jtframe_bank_responder: JTFRAME SDRAM bank responder backed by an internal RAM.
// Optional refresh stall emulation is enabled by defining JTFRAME_BANK_REFRESH_EN.
module jtframe_bank_responder #(
    parameter int AW      = 12,
    parameter int LAT     = 3,
    parameter int BURST   = 2,
    parameter int REFRESH = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          rd,
    input  logic          wr,
    input  logic [15:0]   din,
    input  logic [1:0]    din_m,
    output logic [15:0]   dout,
    output logic          ack,
    output logic          dst,
    output logic          dok,
    output logic          rdy,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [1:0]    prog_mask,
    input  logic          prog_we,
    output logic          prog_rdy,
    output logic          busy
);
    typedef enum logic [2:0] {
        IDLE, ACK, WAIT, DATA, WRITE
`ifdef JTFRAME_BANK_REFRESH_EN
        , REFR
`endif
    } state_t;

    state_t        state, next, req_next;
    logic          op_wr, pw, hold, last;
    logic [3:0]    cnt;
    logic [1:0]    bcnt;
    logic [AW-1:0] ptr, raddr, pa;
    logic [15:0]   pd, rword, rnext;
    logic [1:0]    pm;
    logic [15:0]   mem [0:2**AW-1];

`ifdef JTFRAME_BANK_REFRESH_EN
    localparam int RW = $clog2(REFRESH);
    logic [RW-1:0] rcnt;
    logic          ref_fire, ref_pend, buf_v, buf_ld;
    logic [AW-1:0] buf_a;
    logic [15:0]   buf_d;
    logic [1:0]    buf_m;
    assign ref_fire = rcnt == RW'(REFRESH - 1);
    // prog writes arriving during refresh wait in a one-deep buffer
    assign buf_ld   = prog_we && (state == REFR || buf_v);
    assign pw       = state != REFR && (buf_v || prog_we);
    assign pa       = buf_v ? buf_a : prog_addr;
    assign pd       = buf_v ? buf_d : prog_data;
    assign pm       = buf_v ? buf_m : prog_mask;
    assign hold     = prog_we || buf_v;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rcnt     <= '0;
            ref_pend <= 1'b0;
            buf_v    <= 1'b0;
            buf_a    <= '0;
            buf_d    <= '0;
            buf_m    <= '0;
        end else begin
            rcnt     <= ref_fire ? '0 : rcnt + 1'b1;
            ref_pend <= state == IDLE && next == REFR ? 1'b0 : ref_fire ? 1'b1 : ref_pend;
            buf_v    <= buf_ld ? 1'b1 : state == REFR ? buf_v : 1'b0;
            if (buf_ld) {buf_a, buf_d, buf_m} <= {prog_addr, prog_data, prog_mask};
        end
`else
    assign pw   = prog_we;
    assign pa   = prog_addr;
    assign pd   = prog_data;
    assign pm   = prog_mask;
    assign hold = prog_we;
`endif

    assign last     = bcnt == 2'(BURST - 1);
    assign ack      = state == ACK;
    assign dst      = state == DATA && bcnt == 2'd0;
    assign dok      = state == DATA;
    assign rdy      = (state == DATA && last) || state == WRITE;
    assign busy     = state != IDLE;
    assign req_next = hold ? IDLE : (rd || wr) ? ACK : IDLE;
    // address of the word that dout will carry in the next cycle
    assign raddr    = state == ACK ? addr : state == DATA ? ptr + AW'(1) : ptr;
    assign rword    = mem[raddr];
    assign rnext    = pw && pa == raddr ?
                      {pm[1] ? rword[15:8] : pd[15:8], pm[0] ? rword[7:0] : pd[7:0]} : rword;

    always_comb begin
        next = state;
        case (state)
`ifdef JTFRAME_BANK_REFRESH_EN
            IDLE:    next = ref_pend || ref_fire ? REFR : req_next;
            REFR:    next = cnt == 4'd0 ? req_next : REFR;
`else
            IDLE:    next = req_next;
`endif
            ACK:     next = op_wr ? WRITE : LAT == 1 ? DATA : WAIT;
            WAIT:    next = cnt == 4'd1 ? DATA : WAIT;
            DATA:    next = last ? IDLE : DATA;
            WRITE:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            op_wr    <= 1'b0;
            cnt      <= 4'd0;
            bcnt     <= 2'd0;
            ptr      <= '0;
            dout     <= 16'd0;
            prog_rdy <= 1'b0;
        end else begin
            state    <= next;
            ptr      <= raddr;
            prog_rdy <= pw;
            bcnt     <= state == DATA ? bcnt + 2'd1 : 2'd0;
`ifdef JTFRAME_BANK_REFRESH_EN
            cnt      <= state == ACK ? 4'(LAT - 1) : state == IDLE && next == REFR ? 4'd3 :
                        state == WAIT || state == REFR ? cnt - 4'd1 : cnt;
`else
            cnt      <= state == ACK ? 4'(LAT - 1) : state == WAIT ? cnt - 4'd1 : cnt;
`endif
            if (next == ACK) op_wr <= wr;
            if (next == DATA) dout <= rnext;
        end

    // prog write comes second so it wins a same-word collision with a game write
    always_ff @(posedge clk) begin
        if (state == WRITE) begin
            if (!din_m[1]) mem[ptr][15:8] <= din[15:8];
            if (!din_m[0]) mem[ptr][7:0]  <= din[7:0];
        end
        if (pw) begin
            if (!pm[1]) mem[pa][15:8] <= pd[15:8];
            if (!pm[0]) mem[pa][7:0]  <= pd[7:0];
        end
    end
endmodule

// File: tb/tb_jtframe_bank_responder.sv
// tb_jtframe_bank_responder: directed vector table plus hand-written timing sequences
// for the default build of jtframe_bank_responder (AW=12, LAT=3, BURST=2).
module tb_jtframe_bank_responder;
    localparam int AW = 12, LAT = 3, BURST = 2;

    logic          clk = 1'b0, rst = 1'b1;
    logic [AW-1:0] addr = '0, prog_addr = '0;
    logic          rd = 1'b0, wr = 1'b0, prog_we = 1'b0;
    logic [15:0]   din = '0, prog_data = '0, dout;
    logic [1:0]    din_m = '0, prog_mask = '0;
    logic          ack, dst, dok, rdy, prog_rdy, busy;
    int            n_chk = 0, n_fail = 0;

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [15:0] d;
        logic [1:0]  m;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    jtframe_bank_responder #(.AW(AW), .LAT(LAT), .BURST(BURST), .REFRESH(64)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .din(din), .din_m(din_m),
        .dout(dout), .ack(ack), .dst(dst), .dok(dok), .rdy(rdy),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_rdy(prog_rdy), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic prog_write(input logic [11:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = a; prog_data = d; prog_mask = 2'b00;
        @(posedge clk); #1;
        prog_we = 1'b0;
        @(negedge clk);
        chk("prog_rdy", prog_rdy, 1);
    endtask

    task automatic drive_req(input logic w, input logic [11:0] a, input logic [15:0] d,
                             input logic [1:0] m);
        @(posedge clk); #1;
        wr = w; rd = !w; addr = a; din = d; din_m = m;
    endtask

    task automatic wait_ack(input int exp_n, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 20);
        chk(name, n, exp_n);
    endtask

    task automatic read_tail(input logic [15:0] e0, e1, input string name, input logic keep);
        for (int k = 1; k <= LAT + BURST - 1; k++) begin
            @(negedge clk);
            chk({name, "_dst"}, dst, k == LAT);
            chk({name, "_dok"}, dok, k >= LAT);
            chk({name, "_rdy"}, rdy, k == LAT + BURST - 1);
            if (k >= LAT) chk({name, "_dout"}, dout, k == LAT ? e0 : e1);
        end
        if (!keep) rd = 1'b0;
    endtask

    initial begin
        int seen;
        vecs[0] = '{1'b0, 12'h010, 16'h0000, 2'b00, 16'h1234, 16'hABCD};
        vecs[1] = '{1'b1, 12'h020, 16'h5A5A, 2'b01, 16'h0000, 16'h0000};
        vecs[2] = '{1'b0, 12'h020, 16'h0000, 2'b00, 16'h5AFF, 16'h2121};
        vecs[3] = '{1'b0, 12'hFFF, 16'h0000, 2'b00, 16'h0001, 16'h0002};
        vecs[4] = '{1'b1, 12'h040, 16'hC3C3, 2'b10, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 12'h041, 16'h7777, 2'b00, 16'h0000, 16'h0000};
        vecs[6] = '{1'b1, 12'h041, 16'h0000, 2'b11, 16'h0000, 16'h0000};
        vecs[7] = '{1'b0, 12'h040, 16'h0000, 2'b00, 16'h00C3, 16'h7777};
        vecs[8] = '{1'b1, 12'h000, 16'h9999, 2'b00, 16'h0000, 16'h0000};
        vecs[9] = '{1'b0, 12'hFFF, 16'h0000, 2'b00, 16'h0001, 16'h9999};

        #12;
        chk("reset_outs", {ack, dst, dok, rdy, prog_rdy, busy, dout}, 0);
        @(negedge clk); rst = 1'b0;

        prog_write(12'h010, 16'h1234); prog_write(12'h011, 16'hABCD);
        prog_write(12'h020, 16'hFFFF); prog_write(12'h021, 16'h2121);
        prog_write(12'hFFF, 16'h0001); prog_write(12'h000, 16'h0002);
        prog_write(12'h040, 16'h0000); prog_write(12'h041, 16'h1111);
        prog_write(12'h031, 16'h3131);
        prog_write(12'h050, 16'h0001); prog_write(12'h051, 16'h0002);

        for (int i = 0; i < 10; i++) begin
            drive_req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m);
            wait_ack(2, $sformatf("v%0d_ack", i));
            if (vecs[i].w) begin
                @(negedge clk);
                chk($sformatf("v%0d_wr_rdy", i), rdy, 1);
                chk($sformatf("v%0d_wr_busy", i), busy, 1);
                wr = 1'b0;
            end else begin
                read_tail(vecs[i].e0, vecs[i].e1, $sformatf("v%0d", i), 1'b0);
            end
        end

        // ROM load in the same cycle as a read request delays ack by one cycle
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = 12'h030; prog_data = 16'hBEEF; prog_mask = 2'b00;
        rd = 1'b1; addr = 12'h030;
        @(posedge clk); #1;
        prog_we = 1'b0;
        @(negedge clk);
        chk("prio_prog_rdy", prog_rdy, 1);
        chk("prio_no_ack", ack, 0);
        @(negedge clk);
        chk("prio_ack", ack, 1);
        read_tail(16'hBEEF, 16'h3131, "prio", 1'b0);

        // prog write to the second burst word while the first is on dout
        drive_req(1'b0, 12'h050, 16'h0, 2'b00);
        wait_ack(2, "byp_ack");
        repeat (3) @(posedge clk);
        #1;
        prog_we = 1'b1; prog_addr = 12'h051; prog_data = 16'hAAAA; prog_mask = 2'b00;
        @(negedge clk);
        chk("byp_dst", dst, 1);
        chk("byp_d0", dout, 16'h0001);
        @(posedge clk); #1;
        prog_we = 1'b0;
        @(negedge clk);
        chk("byp_rdy", rdy, 1);
        chk("byp_prog_rdy", prog_rdy, 1);
        chk("byp_d1", dout, 16'hAAAA);
        rd = 1'b0;

        // reset in the middle of the latency wait
        drive_req(1'b0, 12'h010, 16'h0, 2'b00);
        wait_ack(2, "rst_ack");
        @(negedge clk);
        chk("rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_outs", {ack, dst, dok, rdy, prog_rdy, busy, dout}, 0);
        rd = 1'b0;
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (dst || rdy || ack) seen++;
        end
        chk("rst_quiet", seen, 0);

        // back-to-back reads with rd held; memory survives reset
        drive_req(1'b0, 12'h010, 16'h0, 2'b00);
        wait_ack(2, "b2b_ack0");
        read_tail(16'h1234, 16'hABCD, "b2b0", 1'b1);
        @(negedge clk);
        chk("b2b_idle_ack", ack, 0);
        chk("b2b_idle_busy", busy, 0);
        @(negedge clk);
        chk("b2b_ack1", ack, 1);
        read_tail(16'h1234, 16'hABCD, "b2b1", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
